time_set_ctrl: RTL
==================

Name: time_set_ctrl

Overview:
- Sequencer for the digital-clock datapath: steps the user through time-set and alarm-set modes.
- Turns button edges into single-cycle increment pulses for the hour/minute counters, with hold-to-repeat.
- Gates timekeeping and runs the alarm ring sequence with a timeout.
- Sits between the debounced buttons and the hour/minute/second counters, the alarm registers and the alarm comparator.

Parameters:
HOLD_TICKS, 2, ticks of continuous `change` hold before auto-repeat starts
TIMEOUT_TICKS, 30, ticks with no button edge in a set mode before forced return to RUN
RING_TICKS, 60, ticks `alert` stays high unless stopped
SNOOZE_TICKS, 300, snooze length in ticks (used only with SNOOZE_EN)

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
tick  input  1  one-cycle 1 Hz strobe, synchronous to clk
turn  input  1  debounced mode-advance button level
change  input  1  debounced increment button level
reset1  input  1  debounced alarm-stop button level
alarm_match  input  1  comparator level: current HH:MM equals alarm HH:MM
inc_h  output  1  one-cycle hour-increment pulse
inc_m  output  1  one-cycle minute-increment pulse
sel_alarm  output  1  1 = increments target the alarm registers, 0 = time counters
run_en  output  1  timekeeping counters may advance
sec_clr  output  1  one-cycle seconds-clear pulse
blink  output  1  display blink enable for the field being set
state  output  3  current mode, for the display mux
alert  output  1  alarm sounding

Behaviour:
- Reset: all outputs 0 except run_en=1 and state=RUN. All counters 0, ring FSM IDLE, edge registers 0.
- Edge detect: turn, change and reset1 are each registered once. A rise is "now 1, previous 0". All outputs are registered.
- Mode FSM encoding: RUN=0, SET_H=1, SET_M=2, AL_H=3, AL_M=4.
- Mode FSM transitions: a turn rise advances RUN→SET_H→SET_M→AL_H→AL_M→RUN.
- Mode outputs:
  - run_en=0 only in SET_H and SET_M.
  - sel_alarm=1 only in AL_H and AL_M.
  - state reflects the registered FSM state.
- sec_clr: pulses 1 cycle in the cycle after any exit from SET_M, whether by turn or by timeout.
- Increment, single press: a change rise in SET_H or AL_H gives inc_h=1 for exactly 1 cycle, in the cycle after the edge. SET_M and AL_M give inc_m the same way. In RUN, change produces no increment.
- Increment, auto-repeat:
  - A hold counter counts ticks while change=1 and clears when change=0.
  - Once the count ≥ HOLD_TICKS, every further tick while held gives one pulse.
  - The counter saturates and does not wrap.
  - A tick in the same cycle as a change rise gives one pulse, not two.
- Simultaneous turn rise and change rise: turn wins. No increment pulse; hold counter cleared.
- Timeout:
  - An idle counter counts ticks in non-RUN states and clears on any turn or change rise.
  - Reaching TIMEOUT_TICKS forces RUN next cycle and clears the counter.
  - The counter is held at 0 in RUN.
- blink:
  - Set to 1 on entry to any non-RUN state.
  - Toggles on each tick while in a non-RUN state.
  - Forced to 0 in RUN.
- Ring FSM, IDLE: a rise of alarm_match goes to RINGING and clears the ring counter. If a reset1 rise occurs in the same cycle, go straight to DONE instead.
- Ring FSM, RINGING:
  - alert=1.
  - A reset1 rise goes to DONE.
  - The ring counter counts ticks; reaching RING_TICKS goes to DONE.
- Ring FSM, DONE: alert=0; stay until alarm_match=0, then IDLE. A minute cannot retrigger.
- The ring FSM is independent of the mode FSM. Alarm edits made while RINGING do not stop the ring.
- Reset mid-operation: any reset assertion returns immediately to the reset state. Increment pulses in flight are dropped.

Optional Feature:
SNOOZE_EN:
- Defined: in RINGING with mode state RUN, a change rise enters SNOOZE.
  - SNOOZE holds alert=0 and counts SNOOZE_TICKS ticks, then returns to RINGING with the ring counter cleared.
  - A reset1 rise in SNOOZE goes to DONE.
  - alarm_match falling does not end SNOOZE.
- Undefined: no SNOOZE state. The ring FSM ignores change and SNOOZE_TICKS is unused.

Test Plan:
1. Reset then 3 turn rises → state 1,2,3; run_en 1→0→0→1; sec_clr exactly one pulse on the SET_M→AL_H exit; sel_alarm=1 in state 3.
2. In SET_H, 1-cycle change rise → exactly one inc_h pulse, 1 cycle after the edge; inc_m stays 0.
3. In SET_M, hold change for 6 ticks with HOLD_TICKS=2 → 1 press pulse plus 4 repeat inc_m pulses (ticks 3–6); releasing stops pulses.
4. In AL_H, no button activity for 30 ticks → state returns to 0 on the 30th tick + 1 cycle; sec_clr stays 0. Repeat from SET_M → one sec_clr pulse.
5. alarm_match rise → alert=1 next cycle; reset1 rise after 5 ticks → alert=0; alarm_match held high → no re-alert; unstopped ring drops after 60 ticks.
6. SNOOZE_EN: change rise while ringing in RUN → alert=0 for 300 ticks, then alert=1; then reset1 → alert=0, DONE.

Source files
------------

// File: rtl/time_set_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : time_set_ctrl
// Description : Digital-clock mode sequencer: time/alarm set modes, press and
//               hold-to-repeat increments, set-mode timeout, alarm ring FSM.
//               Optional snooze state enabled by defining SNOOZE_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module time_set_ctrl #(
    parameter int HOLD_TICKS    = 2,
    parameter int TIMEOUT_TICKS = 30,
    parameter int RING_TICKS    = 60,
    parameter int SNOOZE_TICKS  = 300
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       turn,
    input  logic       change,
    input  logic       reset1,
    input  logic       alarm_match,
    output logic       inc_h,
    output logic       inc_m,
    output logic       sel_alarm,
    output logic       run_en,
    output logic       sec_clr,
    output logic       blink,
    output logic [2:0] state,
    output logic       alert
);

    localparam logic [2:0] c_run   = 3'd0;
    localparam logic [2:0] c_set_h = 3'd1;
    localparam logic [2:0] c_set_m = 3'd2;
    localparam logic [2:0] c_al_h  = 3'd3;
    localparam logic [2:0] c_al_m  = 3'd4;

    localparam logic [1:0] c_idle    = 2'd0;
    localparam logic [1:0] c_ringing = 2'd1;
    localparam logic [1:0] c_done    = 2'd2;
`ifdef SNOOZE_EN
    localparam logic [1:0] c_snooze  = 2'd3;
`endif

    localparam int c_hold_w = $clog2(HOLD_TICKS + 1);
    localparam int c_idle_w = $clog2(TIMEOUT_TICKS + 1);
    // Ring and snooze never run together, so they share one counter.
    localparam int c_ring_max = (RING_TICKS > SNOOZE_TICKS) ? RING_TICKS : SNOOZE_TICKS;
    localparam int c_ring_w   = $clog2(c_ring_max + 1);

    localparam logic [c_hold_w-1:0] c_hold_sat  = c_hold_w'(HOLD_TICKS);
    localparam logic [c_idle_w-1:0] c_idle_last = c_idle_w'(TIMEOUT_TICKS - 1);
    localparam logic [c_ring_w-1:0] c_ring_last = c_ring_w'(RING_TICKS - 1);
`ifdef SNOOZE_EN
    localparam logic [c_ring_w-1:0] c_snooze_last = c_ring_w'(SNOOZE_TICKS - 1);
`endif

    logic                r_turn_q;
    logic                r_change_q;
    logic                r_reset1_q;
    logic                r_match_q;
    logic [2:0]          r_mode;
    logic [c_idle_w-1:0] r_idle_cnt;
    logic [c_hold_w-1:0] r_hold_cnt;
    logic [1:0]          r_ring;
    logic [c_ring_w-1:0] r_ring_cnt;
    logic                r_inc_h;
    logic                r_inc_m;
    logic                r_sel_alarm;
    logic                r_run_en;
    logic                r_sec_clr;
    logic                r_blink;
    logic                r_alert;

    logic                w_turn_rise;
    logic                w_change_rise;
    logic                w_reset1_rise;
    logic                w_match_rise;
    logic [2:0]          w_mode_next;
    logic [c_idle_w-1:0] w_idle_next;
    logic                w_timeout;
    logic [c_hold_w-1:0] w_hold_next;
    logic                w_repeat;
    logic                w_inc;
    logic                w_blink_next;
    logic [1:0]          w_ring_next;
    logic [c_ring_w-1:0] w_ring_cnt_next;

    assign w_turn_rise   = turn & ~r_turn_q;
    assign w_change_rise = change & ~r_change_q;
    assign w_reset1_rise = reset1 & ~r_reset1_q;
    assign w_match_rise  = alarm_match & ~r_match_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_turn_q   <= 1'b0;
            r_change_q <= 1'b0;
            r_reset1_q <= 1'b0;
            r_match_q  <= 1'b0;
        end else begin
            r_turn_q   <= turn;
            r_change_q <= change;
            r_reset1_q <= reset1;
            r_match_q  <= alarm_match;
        end
    end

    // Mode sequencing and the set-mode inactivity timeout.
    always_comb begin
        w_mode_next = r_mode;
        w_idle_next = r_idle_cnt;
        w_timeout   = 1'b0;
        if (w_turn_rise) begin
            w_idle_next = '0;
            case (r_mode)
                c_run:   w_mode_next = c_set_h;
                c_set_h: w_mode_next = c_set_m;
                c_set_m: w_mode_next = c_al_h;
                c_al_h:  w_mode_next = c_al_m;
                default: w_mode_next = c_run;
            endcase
        end else if (r_mode == c_run || w_change_rise) begin
            w_idle_next = '0;
        end else if (tick) begin
            if (r_idle_cnt == c_idle_last) begin
                w_timeout   = 1'b1;
                w_mode_next = c_run;
                w_idle_next = '0;
            end else begin
                w_idle_next = r_idle_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        w_hold_next = r_hold_cnt;
        if (!change || w_turn_rise) begin
            w_hold_next = '0;
        end else if (tick && (r_hold_cnt != c_hold_sat)) begin
            w_hold_next = r_hold_cnt + 1'b1;
        end
    end

    // A press and a repeat tick in the same cycle merge into one pulse.
    assign w_repeat = change & tick & (r_hold_cnt >= c_hold_sat);
    assign w_inc    = (w_change_rise | w_repeat) & ~w_turn_rise & ~w_timeout;

    always_comb begin
        w_blink_next = r_blink;
        if (w_mode_next == c_run) begin
            w_blink_next = 1'b0;
        end else if (w_mode_next != r_mode) begin
            w_blink_next = 1'b1;
        end else if (tick) begin
            w_blink_next = ~r_blink;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_mode      <= c_run;
            r_idle_cnt  <= '0;
            r_hold_cnt  <= '0;
            r_inc_h     <= 1'b0;
            r_inc_m     <= 1'b0;
            r_sel_alarm <= 1'b0;
            r_run_en    <= 1'b1;
            r_sec_clr   <= 1'b0;
            r_blink     <= 1'b0;
        end else begin
            r_mode      <= w_mode_next;
            r_idle_cnt  <= w_idle_next;
            r_hold_cnt  <= w_hold_next;
            r_inc_h     <= w_inc & ((r_mode == c_set_h) || (r_mode == c_al_h));
            r_inc_m     <= w_inc & ((r_mode == c_set_m) || (r_mode == c_al_m));
            r_sel_alarm <= (w_mode_next == c_al_h) || (w_mode_next == c_al_m);
            r_run_en    <= !((w_mode_next == c_set_h) || (w_mode_next == c_set_m));
            r_sec_clr   <= (r_mode == c_set_m) && (w_mode_next != c_set_m);
            r_blink     <= w_blink_next;
        end
    end

    // Alarm ring sequence; runs regardless of the mode FSM.
    always_comb begin
        w_ring_next     = r_ring;
        w_ring_cnt_next = r_ring_cnt;
        case (r_ring)
            c_idle: begin
                if (w_match_rise) begin
                    w_ring_cnt_next = '0;
                    w_ring_next     = w_reset1_rise ? c_done : c_ringing;
                end
            end
            c_ringing: begin
                if (w_reset1_rise) begin
                    w_ring_next = c_done;
`ifdef SNOOZE_EN
                end else if (w_change_rise && (r_mode == c_run)) begin
                    w_ring_next     = c_snooze;
                    w_ring_cnt_next = '0;
`endif
                end else if (tick) begin
                    if (r_ring_cnt == c_ring_last) begin
                        w_ring_next = c_done;
                    end else begin
                        w_ring_cnt_next = r_ring_cnt + 1'b1;
                    end
                end
            end
            c_done: begin
                if (!alarm_match) begin
                    w_ring_next = c_idle;
                end
            end
`ifdef SNOOZE_EN
            c_snooze: begin
                if (w_reset1_rise) begin
                    w_ring_next = c_done;
                end else if (tick) begin
                    if (r_ring_cnt == c_snooze_last) begin
                        w_ring_next     = c_ringing;
                        w_ring_cnt_next = '0;
                    end else begin
                        w_ring_cnt_next = r_ring_cnt + 1'b1;
                    end
                end
            end
`endif
            default: w_ring_next = c_idle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ring     <= c_idle;
            r_ring_cnt <= '0;
            r_alert    <= 1'b0;
        end else begin
            r_ring     <= w_ring_next;
            r_ring_cnt <= w_ring_cnt_next;
            r_alert    <= (w_ring_next == c_ringing);
        end
    end

    assign inc_h     = r_inc_h;
    assign inc_m     = r_inc_m;
    assign sel_alarm = r_sel_alarm;
    assign run_en    = r_run_en;
    assign sec_clr   = r_sec_clr;
    assign blink     = r_blink;
    assign state     = r_mode;
    assign alert     = r_alert;

endmodule
`default_nettype wire
